// File: rtl/param_pingpong_buf.sv
// param_pingpong_buf: two-bank (ping-pong) parameter buffer for the EPU.
// The AXI-side wrapper fills bank[~act_bank] while the EPU reads bank[act_bank].
// A loaded fill bank is promoted to active as soon as the active bank is
// released (swap_i) or was never valid, so the next layer's parameters
// preload during compute.
//
// Optional feature macro: BUF_READBACK_EN
//   defined   : AXI readback of the fill bank via rd_req_i / rd_addr_i
//   undefined : rd_req_i / rd_addr_i ignored, rvalid_o / rdata_o tied to 0
//
// Strobe semantics: every control input (ld_start_i, ld_fin_i, swap_i, the
// write strobes, the read strobes) is a single-cycle qualifier sampled on the
// rising edge; there is no back-pressure. AXI-side inputs only count when
// enb_i is high. Read responses (epu_rvalid_o, rvalid_o) are one-cycle pulses
// one edge after the request, with the data held until the next request.
module param_pingpong_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb_i,
  input  logic              ld_start_i,
  input  logic              ld_fin_i,
  input  logic              wr_cs_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              epu_cs_i,
  input  logic              epu_oe_i,
  input  logic [ADDR_W-1:0] epu_addr_i,
  output logic [DATA_W-1:0] epu_rdata_o,
  output logic              epu_rvalid_o,
  input  logic              swap_i,
  output logic              act_bank_o,
  output logic              act_vld_o,
  output logic              fill_rdy_o,
  output logic              ld_busy_o,
  output logic [ADDR_W:0]   ld_cnt_o,
  output logic              err_o,
  output logic [1:0]        dbg_fill_state_o
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_LOAD = 2'd1,
    F_FULL = 2'd2
  } fill_state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  // Storage: never reset, only the valid flags are.
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  fill_state_e       state_q, state_d;
  logic              act_bank_q, act_bank_d;
  logic [1:0]        valid_q, valid_d;
  logic [ADDR_W:0]   ld_cnt_q, ld_cnt_d;
  logic              err_q, err_d;
  logic              epu_rvalid_q;
  logic [DATA_W-1:0] epu_rdata_q;

  logic              fill_bank;
  logic              ld_start, ld_fin, wr_req, wr_addr_ok, wr_fire;
  logic              epu_fire, epu_addr_ok;

  assign fill_bank   = ~act_bank_q;
  assign ld_start    = ld_start_i & enb_i;
  assign ld_fin      = ld_fin_i & enb_i;
  assign wr_req      = wr_cs_i & wr_en_i & enb_i;
  assign wr_addr_ok  = ({1'b0, wr_addr_i} < DEPTH_C);
  assign epu_fire    = epu_cs_i & epu_oe_i;
  assign epu_addr_ok = ({1'b0, epu_addr_i} < DEPTH_C);

  // Control state register (fill FSM, bank select, valid flags, load status).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_IDLE;
      act_bank_q <= 1'b0;
      valid_q    <= 2'b00;
      ld_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_bank_q <= act_bank_d;
      valid_q    <= valid_d;
      ld_cnt_q   <= ld_cnt_d;
      err_q      <= err_d;
    end
  end

  // Fill FSM next state, load bookkeeping, promotion and release.
  always_comb begin
    state_d    = state_q;
    act_bank_d = act_bank_q;
    valid_d    = valid_q;
    ld_cnt_d   = ld_cnt_q;
    err_d      = err_q;
    wr_fire    = 1'b0;

    case (state_q)
      F_IDLE: begin
        if (ld_start) begin
          state_d            = F_LOAD;
          valid_d[fill_bank] = 1'b0;
          ld_cnt_d           = '0;
          err_d              = 1'b0;
        end
      end
      F_LOAD: begin
        if (ld_start) begin
          // Restart: the write strobe of this cycle belongs to the old load.
          ld_cnt_d = '0;
          err_d    = 1'b0;
        end else begin
          if (wr_req) begin
            if (wr_addr_ok) begin
              wr_fire = 1'b1;
              if (ld_cnt_q != DEPTH_C) ld_cnt_d = ld_cnt_q + ONE_C;
            end else begin
              err_d = 1'b1;
            end
          end
          if (ld_fin) begin
            state_d            = F_FULL;
            valid_d[fill_bank] = 1'b1;
          end
        end
      end
      F_FULL: begin
        // An explicit overwrite request takes precedence over promotion.
        if (ld_start) begin
          state_d            = F_LOAD;
          valid_d[fill_bank] = 1'b0;
          ld_cnt_d           = '0;
          err_d              = 1'b0;
        end else if (!valid_q[act_bank_q]) begin
          act_bank_d = fill_bank;
          state_d    = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase

    // Release of the active bank; never collides with the fill-bank flag.
    if (swap_i) valid_d[act_bank_q] = 1'b0;
  end

  // Array write port (fill bank, AXI side).
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[fill_bank][wr_addr_i] <= wr_data_i;
  end

  // EPU read port: one-cycle latency, data held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epu_rvalid_q <= 1'b0;
      epu_rdata_q  <= '0;
    end else begin
      epu_rvalid_q <= epu_fire;
      if (epu_fire) begin
        if (valid_q[act_bank_q] && epu_addr_ok) epu_rdata_q <= mem_q[act_bank_q][epu_addr_i];
        else                                    epu_rdata_q <= '0;
      end
    end
  end

`ifdef BUF_READBACK_EN
  logic              rd_fire, rd_addr_ok;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // The fill bank is single-ported: an accepted write drops a readback.
  assign rd_fire    = rd_req_i & enb_i & ~wr_fire;
  assign rd_addr_ok = ({1'b0, rd_addr_i} < DEPTH_C);

  // AXI readback of the fill bank, one-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        if (rd_addr_ok) rdata_q <= mem_q[fill_bank][rd_addr_i];
        else            rdata_q <= '0;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_req_i, rd_addr_i};
  assign rvalid_o  = 1'b0;
  assign rdata_o   = '0;
`endif

  assign epu_rdata_o      = epu_rdata_q;
  assign epu_rvalid_o     = epu_rvalid_q;
  assign act_bank_o       = act_bank_q;
  assign act_vld_o        = valid_q[act_bank_q];
  assign fill_rdy_o       = (state_q == F_FULL);
  assign ld_busy_o        = (state_q == F_LOAD);
  assign ld_cnt_o         = ld_cnt_q;
  assign err_o            = err_q;
  assign dbg_fill_state_o = state_q;

endmodule

// File: tb/tb_param_pingpong_buf.sv
// Directed bench for param_pingpong_buf (small DEPTH=12 so out-of-range
// addresses are representable). Expected values are hand-computed.
module tb_param_pingpong_buf;

  localparam int DW  = 32;
  localparam int DEP = 12;
  localparam int AW  = 4;

  logic          clk, rst;
  logic          enb_i, ld_start_i, ld_fin_i;
  logic          wr_cs_i, wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          epu_cs_i, epu_oe_i;
  logic [AW-1:0] epu_addr_i;
  logic [DW-1:0] epu_rdata_o;
  logic          epu_rvalid_o;
  logic          swap_i;
  logic          act_bank_o, act_vld_o, fill_rdy_o, ld_busy_o;
  logic [AW:0]   ld_cnt_o;
  logic          err_o;
  logic [1:0]    dbg_fill_state_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] exp_q[$];

  param_pingpong_buf #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .enb_i(enb_i),
    .ld_start_i(ld_start_i), .ld_fin_i(ld_fin_i),
    .wr_cs_i(wr_cs_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .epu_cs_i(epu_cs_i), .epu_oe_i(epu_oe_i), .epu_addr_i(epu_addr_i),
    .epu_rdata_o(epu_rdata_o), .epu_rvalid_o(epu_rvalid_o),
    .swap_i(swap_i), .act_bank_o(act_bank_o), .act_vld_o(act_vld_o),
    .fill_rdy_o(fill_rdy_o), .ld_busy_o(ld_busy_o), .ld_cnt_o(ld_cnt_o),
    .err_o(err_o), .dbg_fill_state_o(dbg_fill_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_cs_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_cs_i = 1'b0; wr_en_i = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start_i = 1'b1; tick(); ld_start_i = 1'b0;
  endtask

  task automatic pulse_fin();
    ld_fin_i = 1'b1; tick(); ld_fin_i = 1'b0;
  endtask

  task automatic epu_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    epu_cs_i = 1'b1; epu_oe_i = 1'b1; epu_addr_i = a;
    exp_q.push_back(exp);
    tick();
    epu_cs_i = 1'b0; epu_oe_i = 1'b0;
    check({tag, "_rvalid"}, 32'(epu_rvalid_o), 32'd1);
    check({tag, "_rdata"}, epu_rdata_o, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    enb_i = 1'b0; ld_start_i = 1'b0; ld_fin_i = 1'b0;
    wr_cs_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd_req_i = 1'b0; rd_addr_i = '0;
    epu_cs_i = 1'b0; epu_oe_i = 1'b0; epu_addr_i = '0;
    swap_i = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_act_bank", 32'(act_bank_o), 32'd0);
    check("rst_act_vld",  32'(act_vld_o),  32'd0);
    check("rst_fill_rdy", 32'(fill_rdy_o), 32'd0);
    check("rst_ld_busy",  32'(ld_busy_o),  32'd0);
    check("rst_ld_cnt",   32'(ld_cnt_o),   32'd0);
    check("rst_err",      32'(err_o),      32'd0);
    check("rst_epu_rvld", 32'(epu_rvalid_o), 32'd0);
    check("rst_rvalid",   32'(rvalid_o),   32'd0);
    rst = 1'b0;
    tick();

    // enb_i low gates ld_start_i
    pulse_start();
    check("enb_gate_busy", 32'(ld_busy_o), 32'd0);
    enb_i = 1'b1;

    // Load bank1 with 0x11..0x44, promote, read addr 2
    pulse_start();
    check("t1_busy", 32'(ld_busy_o), 32'd1);
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'((i + 1) * 32'h11));
    check("t1_cnt", 32'(ld_cnt_o), 32'd4);
    pulse_fin();
    check("t1_fill_rdy", 32'(fill_rdy_o), 32'd1);
    check("t1_act_bank_pre", 32'(act_bank_o), 32'd0);
    tick();
    check("t1_fill_rdy_fall", 32'(fill_rdy_o), 32'd0);
    check("t1_act_bank", 32'(act_bank_o), 32'd1);
    check("t1_act_vld", 32'(act_vld_o), 32'd1);
    epu_rd("t1_epu2", 4'd2, 32'h33);
    tick();
    check("t1_rvalid_pulse", 32'(epu_rvalid_o), 32'd0);
    check("t1_rdata_hold", epu_rdata_o, 32'h33);

    // Load bank0 while bank1 active; promotion waits for swap
    pulse_start();
    wr(4'd0, 32'hAA);
    pulse_fin();
    check("t2_fill_rdy", 32'(fill_rdy_o), 32'd1);
    epu_rd("t2_epu_old", 4'd0, 32'h11);
    check("t2_fill_rdy_hold", 32'(fill_rdy_o), 32'd1);
    check("t2_act_bank_hold", 32'(act_bank_o), 32'd1);
    swap_i = 1'b1; tick(); swap_i = 1'b0;
    check("t2_released_vld", 32'(act_vld_o), 32'd0);
    check("t2_released_bank", 32'(act_bank_o), 32'd1);
    // Read in the promotion cycle sees the old (released) bank -> 0
    epu_rd("t2_epu_promo", 4'd0, 32'h0);
    check("t2_act_bank", 32'(act_bank_o), 32'd0);
    check("t2_act_vld", 32'(act_vld_o), 32'd1);
    check("t2_fill_rdy_fall", 32'(fill_rdy_o), 32'd0);
    epu_rd("t2_epu_new", 4'd0, 32'hAA);

    // Out-of-range write during load
    pulse_start();
    wr(4'd1, 32'h77);
    wr(4'd12, 32'hDEAD);
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_cnt", 32'(ld_cnt_o), 32'd1);
    epu_rd("t3_epu_oor", 4'd12, 32'h0);
    pulse_start();
    check("t3_err_clr", 32'(err_o), 32'd0);
    check("t3_cnt_clr", 32'(ld_cnt_o), 32'd0);

    // ld_start with ld_fin in F_LOAD: start wins
    wr(4'd0, 32'h1);
    ld_start_i = 1'b1; ld_fin_i = 1'b1; tick();
    ld_start_i = 1'b0; ld_fin_i = 1'b0;
    check("t4_busy", 32'(ld_busy_o), 32'd1);
    check("t4_cnt", 32'(ld_cnt_o), 32'd0);
    check("t4_fill_rdy", 32'(fill_rdy_o), 32'd0);

    // Counter saturation at DEPTH
    for (int i = 0; i < 14; i++) wr(AW'(i % DEP), DW'(32'h100 + i));
    check("t5_cnt_sat", 32'(ld_cnt_o), 32'(DEP));

    // Readback of the fill bank
    wr(4'd7, 32'h5A);
    check("t5_cnt_sat2", 32'(ld_cnt_o), 32'(DEP));
    rd_req_i = 1'b1; rd_addr_i = 4'd7; tick(); rd_req_i = 1'b0;
`ifdef BUF_READBACK_EN
    check("t6_rvalid", 32'(rvalid_o), 32'd1);
    check("t6_rdata", rdata_o, 32'h5A);
`else
    check("t6_rvalid", 32'(rvalid_o), 32'd0);
    check("t6_rdata", rdata_o, 32'h0);
`endif
    // Readback colliding with a write is dropped
    rd_req_i = 1'b1; rd_addr_i = 4'd7;
    wr(4'd3, 32'h33);
    rd_req_i = 1'b0;
    check("t6_collide_rvalid", 32'(rvalid_o), 32'd0);

    // Asynchronous reset mid-load
    check("t7_busy_pre", 32'(ld_busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t7_busy", 32'(ld_busy_o), 32'd0);
    check("t7_cnt", 32'(ld_cnt_o), 32'd0);
    check("t7_act_vld", 32'(act_vld_o), 32'd0);
    check("t7_act_bank", 32'(act_bank_o), 32'd0);
    check("t7_epu_rdata", epu_rdata_o, 32'h0);
    check("t7_rdata", rdata_o, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("t7_act_vld_post", 32'(act_vld_o), 32'd0);
    check("t7_state_post", 32'(dbg_fill_state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/param_pingpong_buf.md
# param_pingpong_buf

Double-buffered (ping-pong) parameter buffer for the EPU, generalising the single-bank bias wrapper. It holds two banks of DEPTH x DATA_W words. The AXI-side EPU wrapper loads the fill bank while the EPU reads the active bank. Banks swap on an EPU release handshake, so the next layer's bias/scale parameters preload during compute.

## Interface
- DATA_W, 32: word width.
- DEPTH, 512: words per bank.
- ADDR_W, $clog2(DEPTH): address width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enb_i  in  1  wrapper selected by EPU-wrapper address decode; gates all AXI-side inputs.
- ld_start_i  in  1  pulse: begin loading the fill bank.
- ld_fin_i  in  1  pulse: load complete.
- wr_cs_i, wr_en_i  in  1 each  AXI write strobe (both required).
- wr_addr_i  in  ADDR_W  AXI write address.
- wr_data_i  in  DATA_W  AXI write data.
- rd_req_i  in  1  AXI readback request (readback feature only).
- rd_addr_i  in  ADDR_W  readback address.
- rvalid_o  out  1  readback data valid.
- rdata_o  out  DATA_W  readback data.
- epu_cs_i, epu_oe_i  in  1 each  EPU read strobe (both required).
- epu_addr_i  in  ADDR_W  EPU read address.
- epu_rdata_o  out  DATA_W  EPU read data.
- epu_rvalid_o  out  1  EPU read data valid.
- swap_i  in  1  pulse: EPU releases the active bank.
- act_bank_o  out  1  index of the active bank.
- act_vld_o  out  1  active bank holds valid data.
- fill_rdy_o  out  1  fill bank loaded, awaiting promotion.
- ld_busy_o  out  1  load in progress.
- ld_cnt_o  out  ADDR_W+1  words written in the current load; saturates at DEPTH.
- err_o  out  1  sticky: a write hit an address >= DEPTH during load.

## Operation
- Storage: two single-port arrays, bank[0] and bank[1]. The active bank's port is owned by the EPU; the fill bank (~act_bank) port is owned by the AXI side.
- Fill FSM states:
  - F_IDLE: ld_start_i & enb_i -> F_LOAD. Clear valid[fill], ld_cnt, err_o.
  - F_LOAD: write when wr_cs_i & wr_en_i & enb_i & wr_addr_i < DEPTH; each accepted write increments ld_cnt. A write with wr_addr_i >= DEPTH is dropped and sets err_o. ld_start_i & enb_i restarts the load (clear ld_cnt, err_o). Otherwise ld_fin_i & enb_i -> F_FULL and sets valid[fill].
  - F_FULL: fill_rdy_o=1. If act_vld_o=0, promote: act_bank <= fill, -> F_IDLE. ld_start_i & enb_i -> F_LOAD, clearing valid[fill] (overwrite).
- swap_i in any state clears valid[act_bank] (release). A full fill bank then promotes on the following cycle.
- EPU read: epu_cs_i & epu_oe_i reads bank[act_bank][epu_addr_i]. epu_rdata_o returns 0 when act_vld_o=0 or epu_addr_i >= DEPTH; epu_rvalid_o is still asserted.
- Bank contents are never cleared by reset or release; only the valid flags are.

## Timing
- Reset values: act_bank_o=0, valid=2'b00, state F_IDLE. All outputs 0.
- Write: data is in the array on the clock edge at which it is accepted.
- EPU read latency 1 cycle: registered epu_rdata_o and epu_rvalid_o, held until the next read. epu_rvalid_o is a 1-cycle pulse.
- Promotion takes 1 cycle after F_FULL entry (or after the release). act_bank_o toggles, act_vld_o rises and fill_rdy_o falls on the same edge.
- EPU reads issued in the promotion cycle read the old act_bank.
- Simultaneous events:
  - ld_start_i with ld_fin_i: ld_start_i wins.
  - swap_i with ld_fin_i: both take effect; promotion on the next cycle.
  - readback with write in the same cycle: write wins and the read is dropped (rvalid_o stays 0).
- ld_cnt saturates at DEPTH and never wraps.
- Reset mid-load: load aborted, both valid flags cleared.

## Configuration
- BUF_READBACK_EN defined: rd_req_i & enb_i reads bank[fill][rd_addr_i] in any state. rdata_o and rvalid_o are registered with 1-cycle latency; an out-of-range address returns 0 with rvalid_o=1.
- BUF_READBACK_EN undefined: rd_req_i and rd_addr_i are ignored; rvalid_o and rdata_o are tied to 0.

## Test plan
- Reset, load bank1 with 4 words (0x11..0x44 at addr 0..3), pulse ld_fin_i -> fill_rdy_o for 1 cycle, then act_bank_o=1 and act_vld_o=1. EPU read at addr 2 -> epu_rdata_o=0x33 one cycle later.
- With bank1 active, load bank0 addr 0=0xAA and pulse ld_fin_i -> fill_rdy_o stays 1, act_bank_o stays 1. Pulse swap_i -> next cycle act_bank_o=0; EPU read at addr 0 -> 0xAA.
- Write to addr DEPTH during load -> err_o=1 and ld_cnt unchanged. The next ld_start_i clears err_o.
- ld_start_i and ld_fin_i in the same cycle in F_LOAD -> ld_busy_o stays 1 and ld_cnt=0. Assert rst mid-load -> all outputs 0 and act_vld_o=0.
- With BUF_READBACK_EN: after loading 0x5A at addr 7, rd_req_i at addr 7 -> rvalid_o=1 and rdata_o=0x5A next cycle. Without the macro -> rvalid_o stays 0.
